// File: rtl/load_store_unit.sv
// Memory-stage load/store front end: aligns byte addresses to word accesses,
// merges sub-word stores by read-modify-write and extends sub-word loads.
module load_store_unit #(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic [31:0] mem_addr,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        resp_valid,
  output logic [31:0] load_data,
  output logic        misaligned
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [2:0] OP_LB  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_SW  = 3'b010;
  localparam logic [2:0] OP_LW  = 3'b011;
  localparam logic [2:0] OP_LBU = 3'b100;
  localparam logic [2:0] OP_LHU = 3'b101;
  localparam logic [2:0] OP_SB  = 3'b110;
  localparam logic [2:0] OP_SH  = 3'b111;

  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

  state_t      state;
  state_t      next_state;
  logic [2:0]  op_q;
  logic [1:0]  off_q;
  logic [15:0] sdata_q;
  logic [3:0]  cnt;
  logic        fault_q;
  logic        accept;
  logic        req_mis;
  logic        rd_done;
  logic        op_q_store;

  function automatic logic [31:0] extract(input logic [31:0] word,
                                          input logic [2:0]  o,
                                          input logic [1:0]  off);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (o)
      OP_LB:   r = {{24{b[7]}}, b};
      OP_LBU:  r = {24'b0, b};
      OP_LH:   r = {{16{h[15]}}, h};
      OP_LHU:  r = {16'b0, h};
      default: r = word;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] word,
                                        input logic [2:0]  o,
                                        input logic [1:0]  off,
                                        input logic [15:0] sd);
    logic [31:0] r;
    r = word;
    if (o == OP_SB) begin
      case (off)
        2'd0:    r[7:0]   = sd[7:0];
        2'd1:    r[15:8]  = sd[7:0];
        2'd2:    r[23:16] = sd[7:0];
        default: r[31:24] = sd[7:0];
      endcase
    end else if (off[1]) begin
      r[31:16] = sd;
    end else begin
      r[15:0] = sd;
    end
    return r;
  endfunction

  // Any op without a defined access width is reported as a fault.
  always_comb begin
    req_mis = 1'b1;
    case (op)
      OP_LB, OP_LBU, OP_SB: req_mis = 1'b0;
      OP_LH, OP_LHU, OP_SH: req_mis = addr[0];
      OP_LW, OP_SW:         req_mis = (addr[1:0] != 2'b00);
      default:              req_mis = 1'b1;
    endcase
  end

  assign accept     = (state == IDLE) && req_valid;
  assign rd_done    = (cnt == 4'd0);
  assign op_q_store = (op_q[2:1] == 2'b11);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    req_ready  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    resp_valid = 1'b0;
    misaligned = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_mis) begin
            next_state = RESP;
          end else if (op == OP_SW) begin
            next_state = WR;
          end else begin
            next_state = RD;
          end
        end
      end
      RD: begin
        mem_read = 1'b1;
        if (rd_done) begin
          next_state = op_q_store ? WR : RESP;
        end
      end
      WR: begin
        mem_write  = 1'b1;
        next_state = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        misaligned = fault_q;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // mem_addr only moves on acceptance so the memory sees a stable address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= 3'b0;
      off_q     <= 2'b0;
      sdata_q   <= 16'b0;
      cnt       <= 4'b0;
      fault_q   <= 1'b0;
      mem_addr  <= 32'b0;
      mem_wdata <= 32'b0;
      load_data <= 32'b0;
    end else begin
      if (accept) begin
        op_q     <= op;
        off_q    <= addr[1:0];
        sdata_q  <= store_data[15:0];
        fault_q  <= req_mis;
        cnt      <= LAT_M1;
        mem_addr <= {addr[31:2], 2'b00};
        if (!req_mis && (op == OP_SW)) begin
          mem_wdata <= store_data;
        end
      end else if (state == RD) begin
        if (!rd_done) begin
          cnt <= cnt - 4'd1;
        end else if (op_q_store) begin
          mem_wdata <= merge(mem_rdata, op_q, off_q, sdata_q);
        end else begin
          load_data <= extract(mem_rdata, op_q, off_q);
        end
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: one instance at MEM_LAT=1, one at
// MEM_LAT=3, each backed by a small behavioural word memory.
module tb_load_store_unit;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;
  localparam logic [2:0] LW  = 3'b011;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b110;
  localparam logic [2:0] SH  = 3'b111;

  typedef struct {
    logic [31:0] load;
    logic        mis;
    int          lat;
    int          rd;
    int          wr;
    logic [31:0] wdata;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [2:0]  op;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        req_valid_a, req_valid_b;
  logic        req_ready_a, req_ready_b;
  logic [31:0] mem_addr_a, mem_addr_b;
  logic        mem_read_a, mem_read_b;
  logic        mem_write_a, mem_write_b;
  logic [31:0] mem_wdata_a, mem_wdata_b;
  logic [31:0] mem_rdata_a, mem_rdata_b;
  logic        resp_valid_a, resp_valid_b;
  logic [31:0] load_data_a, load_data_b;
  logic        misaligned_a, misaligned_b;

  logic [31:0] mem_a [0:255];
  logic [31:0] mem_b [0:255];
  logic [31:0] ref_a [0:255];

  logic        sel;
  logic        o_ready, o_read, o_write, o_resp, o_mis;
  logic [31:0] o_maddr, o_wdata, o_load;

  exp_t        sbq[$];
  int          checks;
  int          errors;
  int          both_cnt;
  logic [31:0] last_a, last_b;

  load_store_unit #(.MEM_LAT(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid_a), .req_ready(req_ready_a),
    .op(op), .addr(addr), .store_data(store_data), .mem_addr(mem_addr_a),
    .mem_read(mem_read_a), .mem_write(mem_write_a), .mem_wdata(mem_wdata_a),
    .mem_rdata(mem_rdata_a), .resp_valid(resp_valid_a), .load_data(load_data_a),
    .misaligned(misaligned_a)
  );

  load_store_unit #(.MEM_LAT(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid_b), .req_ready(req_ready_b),
    .op(op), .addr(addr), .store_data(store_data), .mem_addr(mem_addr_b),
    .mem_read(mem_read_b), .mem_write(mem_write_b), .mem_wdata(mem_wdata_b),
    .mem_rdata(mem_rdata_b), .resp_valid(resp_valid_b), .load_data(load_data_b),
    .misaligned(misaligned_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata_a = mem_a[mem_addr_a[9:2]];
  assign mem_rdata_b = mem_b[mem_addr_b[9:2]];

  always @(posedge clk) begin
    if (mem_write_a) mem_a[mem_addr_a[9:2]] <= mem_wdata_a;
    if (mem_write_b) mem_b[mem_addr_b[9:2]] <= mem_wdata_b;
  end

  always @(negedge clk) begin
    if ((mem_read_a && mem_write_a) || (mem_read_b && mem_write_b)) both_cnt++;
  end

  assign o_ready = sel ? req_ready_b  : req_ready_a;
  assign o_read  = sel ? mem_read_b   : mem_read_a;
  assign o_write = sel ? mem_write_b  : mem_write_a;
  assign o_resp  = sel ? resp_valid_b : resp_valid_a;
  assign o_mis   = sel ? misaligned_b : misaligned_a;
  assign o_maddr = sel ? mem_addr_b   : mem_addr_a;
  assign o_wdata = sel ? mem_wdata_b  : mem_wdata_a;
  assign o_load  = sel ? load_data_b  : load_data_a;

  function automatic exp_t mk(input logic [31:0] ld, input logic m, input int lt,
                              input int r, input int w, input logic [31:0] wd);
    exp_t e;
    e.load = ld; e.mis = m; e.lat = lt; e.rd = r; e.wr = w; e.wdata = wd;
    return e;
  endfunction

  // Reference behaviour: expected response plus the memory word afterwards.
  function automatic exp_t predict(input logic [2:0] o, input logic [31:0] a,
                                   input logic [31:0] d, input logic [31:0] w,
                                   input logic [31:0] prev, input int lat,
                                   output logic [31:0] nw);
    exp_t        e;
    int          sh8;
    int          sh16;
    logic [7:0]  b;
    logic [15:0] h;
    sh8  = 8 * int'(a[1:0]);
    sh16 = 16 * int'(a[1]);
    b    = 8'((w >> sh8) & 32'hFF);
    h    = 16'((w >> sh16) & 32'hFFFF);
    nw   = w;
    e    = mk(prev, 1'b0, lat + 1, lat, 0, 32'h0);
    case (o)
      LB:  e.load = $unsigned(32'(signed'(b)));
      LBU: e.load = 32'(b);
      LH:  begin e.mis = a[0]; if (!a[0]) e.load = $unsigned(32'(signed'(h))); end
      LHU: begin e.mis = a[0]; if (!a[0]) e.load = 32'(h); end
      LW:  begin e.mis = (a[1:0] != 0); if (!e.mis) e.load = w; end
      SW:  begin e.mis = (a[1:0] != 0); e.lat = 2; e.rd = 0; e.wr = 1; nw = d; end
      SB:  begin
        e.lat = lat + 2; e.wr = 1;
        nw = (w & ~(32'hFF << sh8)) | ((d & 32'hFF) << sh8);
      end
      default: begin
        e.mis = a[0]; e.lat = lat + 2; e.wr = 1;
        nw = (w & ~(32'hFFFF << sh16)) | ((d & 32'hFFFF) << sh16);
      end
    endcase
    if (e.mis) begin
      e.lat = 1; e.rd = 0; e.wr = 0; nw = w;
    end
    e.wdata = nw;
    return e;
  endfunction

  task automatic do_req(input logic s, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] d, input exp_t e, input string name);
    exp_t        x;
    int          cyc, rdc, wrc;
    logic [31:0] wd, exp_maddr;
    logic        stable;
    @(negedge clk);
    sel = s; op = o; addr = a; store_data = d;
    checks++;
    if (o_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL %s ready: got %b expected 1", name, o_ready);
    end
    if (s) req_valid_b = 1'b1; else req_valid_a = 1'b1;
    sbq.push_back(e);
    @(posedge clk); #1;
    req_valid_a = 1'b0; req_valid_b = 1'b0;
    exp_maddr = {a[31:2], 2'b00};
    checks++;
    if (o_maddr !== exp_maddr) begin
      errors++; $display("[TB] FAIL %s mem_addr: got %h expected %h", name, o_maddr, exp_maddr);
    end
    cyc = 1; rdc = 0; wrc = 0; wd = 32'h0; stable = 1'b1;
    while (o_resp !== 1'b1 && cyc < 40) begin
      if (o_read === 1'b1) rdc++;
      if (o_write === 1'b1) begin wrc++; wd = o_wdata; end
      if (o_maddr !== exp_maddr) stable = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    if (o_read === 1'b1) rdc++;
    if (o_write === 1'b1) wrc++;
    if (o_maddr !== exp_maddr) stable = 1'b0;
    x = sbq.pop_front();
    checks++;
    if (o_resp !== 1'b1) begin
      errors++; $display("[TB] FAIL %s timeout: got no resp_valid expected one within 40 cycles", name);
    end else begin
      checks += 6;
      if (cyc != x.lat) begin
        errors++; $display("[TB] FAIL %s latency: got %0d expected %0d", name, cyc, x.lat);
      end
      if (o_load !== x.load) begin
        errors++; $display("[TB] FAIL %s load_data: got %h expected %h", name, o_load, x.load);
      end
      if (o_mis !== x.mis) begin
        errors++; $display("[TB] FAIL %s misaligned: got %b expected %b", name, o_mis, x.mis);
      end
      if (rdc != x.rd) begin
        errors++; $display("[TB] FAIL %s read cycles: got %0d expected %0d", name, rdc, x.rd);
      end
      if (wrc != x.wr) begin
        errors++; $display("[TB] FAIL %s write cycles: got %0d expected %0d", name, wrc, x.wr);
      end
      if (!stable) begin
        errors++; $display("[TB] FAIL %s mem_addr stable: got changes expected %h held", name, exp_maddr);
      end
      if (x.wr > 0) begin
        checks++;
        if (wd !== x.wdata) begin
          errors++; $display("[TB] FAIL %s mem_wdata: got %h expected %h", name, wd, x.wdata);
        end
      end
    end
    @(posedge clk); #1;
    checks++;
    if (o_resp !== 1'b0 || o_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL %s back to idle: got resp=%b ready=%b expected resp=0 ready=1", name, o_resp, o_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks += 4;
    if ({req_ready_a, mem_read_a, mem_write_a, resp_valid_a, misaligned_a} !== 5'b10000) begin
      errors++; $display("[TB] FAIL reset strobes a: got %b expected 10000",
                         {req_ready_a, mem_read_a, mem_write_a, resp_valid_a, misaligned_a});
    end
    if ({req_ready_b, mem_read_b, mem_write_b, resp_valid_b, misaligned_b} !== 5'b10000) begin
      errors++; $display("[TB] FAIL reset strobes b: got %b expected 10000",
                         {req_ready_b, mem_read_b, mem_write_b, resp_valid_b, misaligned_b});
    end
    if (mem_addr_a !== 32'h0 || mem_wdata_a !== 32'h0) begin
      errors++; $display("[TB] FAIL reset mem regs: got %h/%h expected 0/0", mem_addr_a, mem_wdata_a);
    end
    if (load_data_a !== 32'h0) begin
      errors++; $display("[TB] FAIL reset load_data: got %h expected 0", load_data_a);
    end
    @(negedge clk); rst_n = 1'b1;
    last_a = 32'h0; last_b = 32'h0;
  endtask

  task automatic test_loads();
    do_req(0, LW,  32'h40, 32'h0, mk(32'h8899AABB, 0, 2, 1, 0, 0), "lw_0x40");
    do_req(0, LB,  32'h41, 32'h0, mk(32'hFFFFFFAA, 0, 2, 1, 0, 0), "lb_0x41");
    do_req(0, LBU, 32'h43, 32'h0, mk(32'h00000088, 0, 2, 1, 0, 0), "lbu_0x43");
    do_req(0, LHU, 32'h42, 32'h0, mk(32'h00008899, 0, 2, 1, 0, 0), "lhu_0x42");
    do_req(0, LH,  32'h40, 32'h0, mk(32'hFFFFAABB, 0, 2, 1, 0, 0), "lh_0x40");
    last_a = 32'hFFFFAABB;
  endtask

  task automatic test_stores();
    do_req(0, SB, 32'h42, 32'h12345677, mk(last_a, 0, 3, 1, 1, 32'h8877AABB), "sb_0x42");
    do_req(0, LW, 32'h40, 32'h0, mk(32'h8877AABB, 0, 2, 1, 0, 0), "lw_after_sb");
    do_req(0, SW, 32'h44, 32'hCAFEF00D, mk(32'h8877AABB, 0, 2, 0, 1, 32'hCAFEF00D), "sw_0x44");
    do_req(0, LW, 32'h44, 32'h0, mk(32'hCAFEF00D, 0, 2, 1, 0, 0), "lw_after_sw");
    last_a = 32'hCAFEF00D;
  endtask

  task automatic test_misaligned();
    do_req(0, SH,  32'h41, 32'hFFFF, mk(last_a, 1, 1, 0, 0, 0), "sh_0x41");
    do_req(0, LW,  32'h42, 32'h0,    mk(last_a, 1, 1, 0, 0, 0), "lw_0x42");
    do_req(0, LHU, 32'h43, 32'h0,    mk(last_a, 1, 1, 0, 0, 0), "lhu_0x43");
    do_req(0, SW,  32'h46, 32'h1,    mk(last_a, 1, 1, 0, 0, 0), "sw_0x46");
    checks++;
    if (mem_a[16] !== 32'h8877AABB) begin
      errors++; $display("[TB] FAIL fault memory word: got %h expected 8877aabb", mem_a[16]);
    end
  endtask

  task automatic test_long_latency();
    do_req(1, SH, 32'h40, 32'h0000BEEF, mk(32'h0, 0, 5, 3, 1, 32'h8899BEEF), "lat3_sh_0x40");
    do_req(1, LH, 32'h42, 32'h0, mk(32'hFFFF8899, 0, 4, 3, 0, 0), "lat3_lh_0x42");
    do_req(1, LBU, 32'h40, 32'h0, mk(32'h000000EF, 0, 4, 3, 0, 0), "lat3_lbu_0x40");
    checks++;
    if (both_cnt != 0) begin
      errors++; $display("[TB] FAIL read and write overlap: got %0d cycles expected 0", both_cnt);
    end
  endtask

  task automatic test_back_to_back();
    exp_t x;
    int   cyc;
    @(negedge clk);
    sel = 0; op = LW; addr = 32'h40; store_data = 32'h0; req_valid_a = 1'b1;
    sbq.push_back(mk(32'h8877AABB, 0, 2, 1, 0, 0));
    @(posedge clk); #1;
    op = LBU; addr = 32'h43;
    sbq.push_back(mk(32'h00000088, 0, 2, 1, 0, 0));
    checks += 2;
    if (req_ready_a !== 1'b0) begin
      errors++; $display("[TB] FAIL b2b busy ready: got %b expected 0", req_ready_a);
    end
    cyc = 1;
    while (resp_valid_a !== 1'b1 && cyc < 10) begin @(posedge clk); #1; cyc++; end
    x = sbq.pop_front();
    if (resp_valid_a !== 1'b1 || load_data_a !== x.load || mem_addr_a !== 32'h40) begin
      errors++; $display("[TB] FAIL b2b first: got resp=%b data=%h addr=%h expected 1/%h/00000040",
                         resp_valid_a, load_data_a, mem_addr_a, x.load);
    end
    @(posedge clk); #1;
    checks++;
    if (req_ready_a !== 1'b1 || mem_read_a !== 1'b0) begin
      errors++; $display("[TB] FAIL b2b idle gap: got ready=%b read=%b expected 1/0", req_ready_a, mem_read_a);
    end
    @(posedge clk); #1;
    req_valid_a = 1'b0;
    checks++;
    if (mem_read_a !== 1'b1 || mem_addr_a !== 32'h40) begin
      errors++; $display("[TB] FAIL b2b second accept: got read=%b addr=%h expected 1/00000040", mem_read_a, mem_addr_a);
    end
    cyc = 1;
    while (resp_valid_a !== 1'b1 && cyc < 10) begin @(posedge clk); #1; cyc++; end
    x = sbq.pop_front();
    checks++;
    if (resp_valid_a !== 1'b1 || load_data_a !== x.load || cyc != x.lat) begin
      errors++; $display("[TB] FAIL b2b second: got resp=%b data=%h lat=%0d expected 1/%h/%0d",
                         resp_valid_a, load_data_a, cyc, x.load, x.lat);
    end
    @(posedge clk); #1;
    last_a = 32'h00000088;
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    sel = 0; op = SB; addr = 32'h81; store_data = 32'h55; req_valid_a = 1'b1;
    @(posedge clk); #1;
    req_valid_a = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks += 2;
    if ({mem_read_a, mem_write_a, resp_valid_a, req_ready_a} !== 4'b0001) begin
      errors++; $display("[TB] FAIL async reset strobes: got %b expected 0001",
                         {mem_read_a, mem_write_a, resp_valid_a, req_ready_a});
    end
    if (load_data_a !== 32'h0 || mem_addr_a !== 32'h0) begin
      errors++; $display("[TB] FAIL async reset regs: got %h/%h expected 0/0", load_data_a, mem_addr_a);
    end
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (mem_a[32] !== 32'h11223344) begin
      errors++; $display("[TB] FAIL async reset memory: got %h expected 11223344", mem_a[32]);
    end
    last_a = 32'h0; last_b = 32'h0;
    do_req(0, LW, 32'h80, 32'h0, mk(32'h11223344, 0, 2, 1, 0, 0), "lw_after_reset");
    last_a = 32'h11223344;
  endtask

  task automatic test_random();
    exp_t        e;
    logic [31:0] a, d, nw;
    logic [2:0]  o;
    int          idx, diff;
    for (int n = 0; n < 24; n++) begin
      idx = $urandom_range(64, 127);
      a   = 32'(idx * 4 + $urandom_range(0, 3));
      d   = $urandom;
      o   = 3'($urandom_range(0, 7));
      e   = predict(o, a, d, ref_a[idx], last_a, 1, nw);
      do_req(0, o, a, d, e, "random");
      ref_a[idx] = nw;
      last_a = e.load;
    end
    diff = 0;
    for (int i = 64; i < 128; i++) if (mem_a[i] !== ref_a[i]) diff++;
    checks++;
    if (diff != 0) begin
      errors++; $display("[TB] FAIL random memory image: got %0d differing words expected 0", diff);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no finish expected finish before 100us");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks = 0; errors = 0; both_cnt = 0;
    sel = 1'b0; op = 3'b0; addr = 32'h0; store_data = 32'h0;
    req_valid_a = 1'b0; req_valid_b = 1'b0;
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = 32'(i) * 32'h01030507 ^ 32'hA5A55A5A;
      mem_b[i] = 32'h0;
      ref_a[i] = mem_a[i];
    end
    mem_a[16] = 32'h8899AABB;
    mem_a[32] = 32'h11223344;
    mem_b[16] = 32'h8899AABB;
    test_reset();
    test_loads();
    test_stores();
    test_misaligned();
    test_long_latency();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-stage front end placed directly upstream of the word-addressed data memory.
- Accepts one load/store request per transaction from the EX/MEM stage and issues word-aligned accesses to the memory: byte address in, word address bits [1:0]=00 out.
- Performs read-modify-write for SB/SH and byte-lane extraction with sign/zero extension for LB/LBU/LH/LHU.
- Flags misaligned accesses instead of touching memory.

Parameters:
- MEM_LAT, 1, cycles mem_read is held before mem_rdata is sampled (legal 1..15).

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit idle and able to accept a request
- op  in  3  000 LB, 001 LH, 011 LW, 100 LBU, 101 LHU, 110 SB, 111 SH, 010 SW
- addr  in  32  byte address
- store_data  in  32  store operand; SB uses [7:0], SH uses [15:0]
- mem_addr  out  32  word-aligned address to data memory
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_wdata  out  32  full word to write
- mem_rdata  in  32  word returned by memory
- resp_valid  out  1  one-cycle completion pulse
- load_data  out  32  extended load result, valid with resp_valid
- misaligned  out  1  alignment fault, valid with resp_valid

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - mem_read, mem_write, resp_valid and misaligned go to 0.
  - mem_addr, mem_wdata and load_data go to 0.
  - req_ready=1.
  - An in-flight RMW is abandoned and mem_write drops immediately.
- States: IDLE, RD, WR, RESP.
  - IDLE: req_ready=1. A request is accepted on a rising edge with req_valid=1; addr, op and store_data are latched.
  - Misaligned requests go to RESP with misaligned=1. No memory strobe is asserted.
  - Misaligned means LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0.
  - Loads and SB/SH go to RD. SW goes to WR.
  - Undefined op values are treated as misaligned.
  - RD: mem_read=1 for exactly MEM_LAT cycles, counted by a 4-bit counter. mem_rdata is sampled on the edge ending the last RD cycle. Loads then go to RESP; SB/SH go to WR.
  - WR: mem_write=1 for exactly one cycle, then RESP.
    - SW: mem_wdata=store_data.
    - SB: mem_wdata is the sampled word with lane addr[1:0] replaced by store_data[7:0].
    - SH: mem_wdata is the sampled word with half addr[1] replaced by store_data[15:0].
  - RESP: resp_valid=1 for one cycle, then IDLE. req_ready=0.
- Byte lanes are little-endian: offset 0 maps to [7:0] and offset 3 to [31:24].
- Load extension:
  - LB/LH sign-extend from bit 7/15.
  - LBU/LHU zero-extend.
  - LW passes the word through.
- load_data is updated only at RESP entry for loads; stores and faults leave it unchanged. misaligned is 0 in RESP for non-faulting requests.
- mem_addr={addr[31:2],2'b00}. It is set on acceptance and held stable through RD/WR/RESP and while IDLE, because the memory reacts to address changes.
- mem_read and mem_write are never both 1. Both are 0 outside RD/WR.
- Latency from the accepting edge to the resp_valid cycle:
  - loads: MEM_LAT+1 cycles
  - SW: 2 cycles
  - SB/SH: MEM_LAT+2 cycles
  - fault: 1 cycle
- Back-to-back: the earliest next acceptance is the edge after RESP, so no requests overlap.
- req_valid asserted while req_ready=0 is ignored. The upstream stage holds the request and stalls on !req_ready.

Test Plan:
- Memory word 0x40 = 0x8899AABB, MEM_LAT=1. LW addr 0x40 → mem_read high for 1 cycle with mem_addr 0x40; resp_valid 2 cycles after accept; load_data 0x8899AABB; misaligned=0.
- Same word:
  - LB addr 0x41 → load_data 0xFFFFFFAA.
  - LBU addr 0x43 → 0x00000088.
  - LHU addr 0x42 → 0x00008899.
  - LH addr 0x40 → 0xFFFFAABB.
- SB addr 0x42, store_data 0x12345677 → one RD then one WR with mem_wdata 0x8877AABB; resp_valid at accept+3; a following LW returns 0x8877AABB.
- SH addr 0x41 and LW addr 0x42 → misaligned=1 with resp_valid 1 cycle after accept; mem_read and mem_write stay 0; memory is unchanged.
- MEM_LAT=3, SH addr 0x40, store_data 0xBEEF → mem_read high for 3 cycles, mem_write high for 1 cycle with 0x8899BEEF; never both high.
- rst_n pulled low during the RD of an SB → mem_read, mem_write and resp_valid go to 0 at once; no write occurs; req_ready=1; memory word is unchanged.
